instr_mem_loader: RTL

//  Boot-time program loader upstream of the MIPS instruction memory. Receives a framed byte

---
 rtl/instr_mem_loader_pkg.sv | 19 +
 rtl/instr_mem_loader_if.sv | 9 +
 rtl/instr_mem_loader_timeout.sv | 27 ++
 rtl/instr_mem_loader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader: FSM states and error codes.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte stream handshake feeding the loader: master is the byte source, slave is the loader.
interface instr_mem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/instr_mem_loader_timeout.sv
// Idle-cycle watchdog: counts cycles without an accepted byte while a frame is open.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || !run || kick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Fires on the edge that would make the idle count reach TIMEOUT_CYC.
  assign expired = run && !kick && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Framed byte-stream program loader: assembles big-endian words, writes instruction memory,
// and releases the core reset only after a frame with a matching XOR checksum.
module instr_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_mem_loader_if.slave rx,
  output logic              instr_WE,
  output logic [ADDR_W-1:0] instr_WA,
  output logic [31:0]       instr_WD,
  output logic              core_rstn,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  loader_state_t     state_reg;
  logic [15:0]       len_reg;
  logic [15:0]       word_idx_reg;
  logic [1:0]        byte_idx_reg;
  logic [23:0]       shift_reg;
  logic [7:0]        csum_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] wa_reg;
  logic [31:0]       wd_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              core_rstn_reg;
  logic [1:0]        err_reg;

  logic              accept;
  logic              tmo_expired;
  logic [15:0]       len_full;

  assign accept   = rx.rx_valid && busy_reg;
  assign len_full = {len_reg[15:8], rx.rx_data};

  loader_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (busy_reg),
    .kick   (accept),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      word_idx_reg  <= '0;
      byte_idx_reg  <= '0;
      shift_reg     <= '0;
      csum_reg      <= '0;
      we_reg        <= 1'b0;
      wa_reg        <= '0;
      wd_reg        <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      core_rstn_reg <= 1'b0;
      err_reg       <= ERR_NONE;
    end else begin
      we_reg <= 1'b0;
      if (tmo_expired) begin
        state_reg <= ST_ERR;
        busy_reg  <= 1'b0;
        err_reg   <= ERR_TMO;
      end else begin
        unique case (state_reg)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
              state_reg     <= ST_LEN_HI;
              busy_reg      <= 1'b1;
              done_reg      <= 1'b0;
              core_rstn_reg <= 1'b0;
              err_reg       <= ERR_NONE;
              word_idx_reg  <= '0;
              byte_idx_reg  <= '0;
              csum_reg      <= '0;
            end
          end
          ST_LEN_HI: begin
            if (accept) begin
              len_reg[15:8] <= rx.rx_data;
              state_reg     <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (accept) begin
              len_reg <= len_full;
              // Full 16-bit compare so lengths above DEPTH cannot alias after narrowing.
              if ({1'b0, len_full} > 17'(DEPTH)) begin
                state_reg <= ST_ERR;
                busy_reg  <= 1'b0;
                err_reg   <= ERR_LEN;
              end else if (len_full == 16'd0) begin
                state_reg <= ST_CSUM;
              end else begin
                state_reg <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (accept) begin
              shift_reg    <= {shift_reg[15:0], rx.rx_data};
              csum_reg     <= csum_reg ^ rx.rx_data;
              byte_idx_reg <= byte_idx_reg + 2'd1;
              if (byte_idx_reg == 2'd3) begin
                we_reg       <= 1'b1;
                wa_reg       <= word_idx_reg[ADDR_W-1:0];
                wd_reg       <= {shift_reg, rx.rx_data};
                word_idx_reg <= word_idx_reg + 16'd1;
                if (word_idx_reg + 16'd1 == len_reg) begin
                  state_reg <= ST_CSUM;
                end
              end
            end
          end
          ST_CSUM: begin
            if (accept) begin
              busy_reg <= 1'b0;
              if (rx.rx_data == csum_reg) begin
                state_reg     <= ST_DONE;
                done_reg      <= 1'b1;
                core_rstn_reg <= 1'b1;
              end else begin
                state_reg <= ST_ERR;
                err_reg   <= ERR_CSUM;
              end
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.rx_ready = busy_reg;
  assign instr_WE    = we_reg;
  assign instr_WA    = wa_reg;
  assign instr_WD    = wd_reg;
  assign core_rstn   = core_rstn_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err_code    = err_reg;

endmodule
